// File: rtl/trap_seq_ctrl.sv
// Trap entry / mret sequencer in front of the machine-mode CSR file.
// Owns the CSR port while a sequence runs and passes core CSR accesses through when idle.
module trap_seq_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int VECTORED_EN = 1,
    parameter int MIE_BIT     = 3,
    parameter int MPIE_BIT    = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              trap_req_i,
    input  logic [31:0]       trap_pc_i,
    input  logic [31:0]       trap_cause_i,
    output logic              trap_ack_o,
    input  logic              mret_req_i,
    output logic              mret_ack_o,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic [31:0]       core_rdata_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic              csr_re_o,
    output logic [31:0]       csr_wdata_o,
    input  logic [31:0]       csr_rdata_i,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o,
    output logic              busy_o
);
    // state      | meaning
    // IDLE       | core CSR port passed through; requests evaluated
    // T_RD_ST    | read mstatus
    // T_CAP_ST   | capture mstatus
    // T_WR_EPC   | write mepc = pc & ~3
    // T_WR_CAUSE | write mcause
    // T_WR_ST    | write mstatus (MPIE := MIE, MIE := 0)
    // T_RD_VEC   | read mtvec
    // T_CAP_VEC  | compute trap target
    // M_RD_ST    | read mstatus
    // M_CAP_ST   | capture mstatus
    // M_RD_EPC   | read mepc
    // M_CAP_EPC  | capture return target
    // M_WR_ST    | write mstatus (MIE := MPIE, MPIE := 1)
    // DONE       | redirect pulse
    typedef enum logic [3:0] {
        IDLE, T_RD_ST, T_CAP_ST, T_WR_EPC, T_WR_CAUSE, T_WR_ST, T_RD_VEC, T_CAP_VEC,
        M_RD_ST, M_CAP_ST, M_RD_EPC, M_CAP_EPC, M_WR_ST, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
    localparam logic [ADDR_W-1:0] A_MTVEC   = ADDR_W'(12'h305);
    localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);

    state_t      state;
    logic [31:0] pc_q, cause_q, status_q, target_q;
    logic        redirect_q;
    logic        idle;
    logic [31:0] status_trap, status_mret, vec_base, vec_target;
    logic        vec_hit;

    assign idle             = (state == IDLE);
    assign trap_ack_o       = idle & trap_req_i;
    assign mret_ack_o       = idle & mret_req_i & ~trap_req_i;
    assign core_gnt_o       = idle & core_req_i & ~trap_req_i & ~mret_req_i;
    assign core_rdata_o     = csr_rdata_i;
    assign busy_o           = ~idle;
    assign redirect_valid_o = redirect_q;
    assign redirect_pc_o    = target_q;

    always_comb begin
        status_trap           = status_q;
        status_trap[MPIE_BIT] = status_q[MIE_BIT];
        status_trap[MIE_BIT]  = 1'b0;
        status_mret           = status_q;
        status_mret[MIE_BIT]  = status_q[MPIE_BIT];
        status_mret[MPIE_BIT] = 1'b1;
    end

    // Vectored mode only for interrupts with MODE=1; MODE 2/3 fall back to direct.
    assign vec_base   = {csr_rdata_i[31:2], 2'b00};
    assign vec_hit    = (VECTORED_EN != 0) && (csr_rdata_i[1:0] == 2'b01) && cause_q[31];
    assign vec_target = vec_hit ? vec_base + {cause_q[29:0], 2'b00} : vec_base;

    always_comb begin
        csr_addr_o  = '0;
        csr_we_o    = 1'b0;
        csr_re_o    = 1'b0;
        csr_wdata_o = '0;
        case (state)
            IDLE: if (core_gnt_o) begin
                csr_addr_o  = core_addr_i;
                csr_we_o    = core_we_i;
                csr_re_o    = ~core_we_i;
                csr_wdata_o = core_wdata_i;
            end
            T_RD_ST, M_RD_ST: begin
                csr_addr_o = A_MSTATUS;
                csr_re_o   = 1'b1;
            end
            T_WR_EPC: begin
                csr_addr_o  = A_MEPC;
                csr_we_o    = 1'b1;
                csr_wdata_o = pc_q & ~32'h3;
            end
            T_WR_CAUSE: begin
                csr_addr_o  = A_MCAUSE;
                csr_we_o    = 1'b1;
                csr_wdata_o = cause_q;
            end
            T_WR_ST: begin
                csr_addr_o  = A_MSTATUS;
                csr_we_o    = 1'b1;
                csr_wdata_o = status_trap;
            end
            T_RD_VEC: begin
                csr_addr_o = A_MTVEC;
                csr_re_o   = 1'b1;
            end
            M_RD_EPC: begin
                csr_addr_o = A_MEPC;
                csr_re_o   = 1'b1;
            end
            M_WR_ST: begin
                csr_addr_o  = A_MSTATUS;
                csr_we_o    = 1'b1;
                csr_wdata_o = status_mret;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            pc_q       <= '0;
            cause_q    <= '0;
            status_q   <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (trap_req_i) begin
                        pc_q    <= trap_pc_i;
                        cause_q <= trap_cause_i;
                        state   <= T_RD_ST;
                    end else if (mret_req_i) begin
                        state <= M_RD_ST;
                    end
                end
                T_RD_ST:    state <= T_CAP_ST;
                T_CAP_ST: begin
                    status_q <= csr_rdata_i;
                    state    <= T_WR_EPC;
                end
                T_WR_EPC:   state <= T_WR_CAUSE;
                T_WR_CAUSE: state <= T_WR_ST;
                T_WR_ST:    state <= T_RD_VEC;
                T_RD_VEC:   state <= T_CAP_VEC;
                T_CAP_VEC: begin
                    target_q   <= vec_target;
                    redirect_q <= 1'b1;
                    state      <= DONE;
                end
                M_RD_ST:    state <= M_CAP_ST;
                M_CAP_ST: begin
                    status_q <= csr_rdata_i;
                    state    <= M_RD_EPC;
                end
                M_RD_EPC:   state <= M_CAP_EPC;
                M_CAP_EPC: begin
                    target_q <= csr_rdata_i & ~32'h3;
                    state    <= M_WR_ST;
                end
                M_WR_ST: begin
                    redirect_q <= 1'b1;
                    state      <= DONE;
                end
                DONE:       state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Directed bench for trap_seq_ctrl with a behavioural CSR file behind it.
// A second instance with VECTORED_EN = 0 shadows the first for the direct-mode target.
module tb_trap_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_req = 1'b0, mret_req = 1'b0, core_req = 1'b0, core_we = 1'b0;
    logic [31:0] trap_pc = '0, trap_cause = '0, core_addr = '0, core_wdata = '0;
    logic        trap_ack, mret_ack, core_gnt, csr_we, csr_re, redirect_valid, busy;
    logic [31:0] core_rdata, csr_addr, csr_wdata, redirect_pc;
    logic [31:0] csr_rdata = '0;
    logic        nv_trap_ack, nv_mret_ack, nv_gnt, nv_we, nv_re, nv_redirect_valid, nv_busy;
    logic [31:0] nv_core_rdata, nv_addr, nv_wdata, nv_redirect_pc;

    logic [31:0] mem [32];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    trap_seq_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .trap_req_i(trap_req), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .trap_ack_o(trap_ack),
        .mret_req_i(mret_req), .mret_ack_o(mret_ack),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rdata_o(core_rdata),
        .csr_addr_o(csr_addr), .csr_we_o(csr_we), .csr_re_o(csr_re), .csr_wdata_o(csr_wdata),
        .csr_rdata_i(csr_rdata),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .busy_o(busy)
    );

    trap_seq_ctrl #(.VECTORED_EN(0)) dut_nv (
        .clk_i(clk), .rst_ni(rst_n),
        .trap_req_i(trap_req), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .trap_ack_o(nv_trap_ack),
        .mret_req_i(mret_req), .mret_ack_o(nv_mret_ack),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(nv_gnt), .core_rdata_o(nv_core_rdata),
        .csr_addr_o(nv_addr), .csr_we_o(nv_we), .csr_re_o(nv_re), .csr_wdata_o(nv_wdata),
        .csr_rdata_i(csr_rdata),
        .redirect_valid_o(nv_redirect_valid), .redirect_pc_o(nv_redirect_pc), .busy_o(nv_busy)
    );

    // CSR file model: registered read, one-cycle write, indexed by the low address bits.
    always @(posedge clk) begin
        if (csr_we) begin
            mem[csr_addr[4:0]] <= csr_wdata;
            wr_addr.push_back(csr_addr);
            wr_data.push_back(csr_wdata);
        end
        if (csr_re) csr_rdata <= mem[csr_addr[4:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [31:0] a, input logic [31:0] d);
        core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
        tick();
        core_req = 1'b0; core_we = 1'b0;
    endtask

    // Called one cycle after the accept edge; returns the cycle index of the redirect (20 = none).
    task automatic run_to_redirect(output int n);
        n = 1;
        while (redirect_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, trap_ack, mret_ack, core_gnt, csr_we, csr_re, redirect_valid} !== 7'b0)
            $display("FAIL reset_ctrl got %b want 0000000", {busy, trap_ack, mret_ack, core_gnt, csr_we, csr_re, redirect_valid});
        else n_pass++;
        n_checks++;
        if (redirect_pc !== 32'h0) $display("FAIL reset_pc got %h want 00000000", redirect_pc);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_core_access();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h305; core_wdata = 32'h8000_0100;
        #1;
        n_checks++;
        if ({core_gnt, csr_we, csr_re} !== 3'b110 || csr_addr !== 32'h305 || csr_wdata !== 32'h8000_0100)
            $display("FAIL core_write got gnt/we/re=%b addr=%h data=%h want 110 305 80000100", {core_gnt, csr_we, csr_re}, csr_addr, csr_wdata);
        else n_pass++;
        tick();
        core_write(32'h300, 32'h0000_0008);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h305;
        #1;
        n_checks++;
        if ({core_gnt, csr_we, csr_re} !== 3'b101 || csr_addr !== 32'h305)
            $display("FAIL core_read_gnt got gnt/we/re=%b addr=%h want 101 305", {core_gnt, csr_we, csr_re}, csr_addr);
        else n_pass++;
        tick();
        core_req = 1'b0;
        n_checks++;
        if (core_rdata !== 32'h8000_0100) $display("FAIL core_rdata got %h want 80000100", core_rdata);
        else n_pass++;
    endtask

    task automatic test_direct_trap();
        int n;
        wr_addr.delete(); wr_data.delete();
        trap_pc = 32'h0000_1236; trap_cause = 32'h0000_0002; trap_req = 1'b1;
        #1;
        n_checks++;
        if (trap_ack !== 1'b1 || busy !== 1'b0) $display("FAIL trap_ack got ack=%b busy=%b want 1 0", trap_ack, busy);
        else n_pass++;
        tick();
        trap_req = 1'b0;
        n_checks++;
        if (trap_ack !== 1'b0 || busy !== 1'b1) $display("FAIL trap_busy got ack=%b busy=%b want 0 1", trap_ack, busy);
        else n_pass++;
        run_to_redirect(n);
        n_checks++;
        if (n !== 8) $display("FAIL trap_latency got %0d want 8", n);
        else n_pass++;
        n_checks++;
        if (redirect_pc !== 32'h8000_0100 || nv_redirect_pc !== 32'h8000_0100)
            $display("FAIL trap_target got %h/%h want 80000100/80000100", redirect_pc, nv_redirect_pc);
        else n_pass++;
        tick();
        n_checks++;
        if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== 32'h8000_0100)
            $display("FAIL trap_after got rv=%b busy=%b pc=%h want 0 0 80000100", redirect_valid, busy, redirect_pc);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() !== 3) $display("FAIL trap_wr_count got %0d want 3", wr_addr.size());
        else if (wr_addr[0] !== 32'h341 || wr_data[0] !== 32'h1234 || wr_addr[1] !== 32'h342 || wr_data[1] !== 32'h2
                 || wr_addr[2] !== 32'h300 || wr_data[2] !== 32'h80)
            $display("FAIL trap_writes got %h=%h %h=%h %h=%h want 341=1234 342=2 300=80",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
        else n_pass++;
    endtask

    task automatic test_vectored();
        logic [31:0] tv [4][4];
        int n;
        tv[0] = '{32'h8000_0101, 32'h8000_0007, 32'h8000_011C, 32'h8000_0100};
        tv[1] = '{32'h8000_0101, 32'h0000_0002, 32'h8000_0100, 32'h8000_0100};
        tv[2] = '{32'h8000_0102, 32'h8000_0007, 32'h8000_0100, 32'h8000_0100};
        tv[3] = '{32'hFFFF_FF01, 32'h8000_0080, 32'h0000_0100, 32'hFFFF_FF00};
        for (int i = 0; i < 4; i++) begin
            core_write(32'h305, tv[i][0]);
            trap_pc = 32'h0000_3000; trap_cause = tv[i][1]; trap_req = 1'b1;
            tick();
            trap_req = 1'b0;
            run_to_redirect(n);
            n_checks++;
            if (n !== 8 || redirect_pc !== tv[i][2] || nv_redirect_pc !== tv[i][3])
                $display("FAIL vec_target[%0d] got n=%0d pc=%h nv=%h want 8 %h %h", i, n, redirect_pc, nv_redirect_pc, tv[i][2], tv[i][3]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mret();
        int n;
        core_write(32'h341, 32'h0000_1234);
        core_write(32'h300, 32'h0000_0080);
        wr_addr.delete(); wr_data.delete();
        mret_req = 1'b1;
        #1;
        n_checks++;
        if (mret_ack !== 1'b1 || trap_ack !== 1'b0) $display("FAIL mret_ack got %b/%b want 1/0", mret_ack, trap_ack);
        else n_pass++;
        tick();
        mret_req = 1'b0;
        run_to_redirect(n);
        n_checks++;
        if (n !== 6 || redirect_pc !== 32'h1234) $display("FAIL mret_redirect got n=%0d pc=%h want 6 00001234", n, redirect_pc);
        else n_pass++;
        tick();
        n_checks++;
        if (wr_addr.size() !== 1) $display("FAIL mret_wr_count got %0d want 1", wr_addr.size());
        else if (wr_addr[0] !== 32'h300 || wr_data[0] !== 32'h88)
            $display("FAIL mret_write got %h=%h want 300=88", wr_addr[0], wr_data[0]);
        else n_pass++;
    endtask

    task automatic test_contention();
        int k = 0;
        int viol = 0;
        logic saw_rv = 1'b0;
        trap_pc = 32'h0000_2000; trap_cause = 32'h0000_0003;
        trap_req = 1'b1; mret_req = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h305;
        #1;
        n_checks++;
        if ({trap_ack, mret_ack, core_gnt} !== 3'b100) $display("FAIL contend_idle got %b want 100", {trap_ack, mret_ack, core_gnt});
        else n_pass++;
        tick();
        trap_req = 1'b0;
        while (busy === 1'b1 && k < 20) begin
            if (mret_ack !== 1'b0 || core_gnt !== 1'b0 || csr_re === 1'b1 && csr_addr === 32'h305 && k != 5) viol++;
            if (redirect_valid === 1'b1) saw_rv = 1'b1;
            tick();
            k++;
        end
        n_checks++;
        if (viol !== 0 || !saw_rv || k !== 8) $display("FAIL contend_busy got viol=%0d rv=%b cycles=%0d want 0 1 8", viol, saw_rv, k);
        else n_pass++;
        n_checks++;
        if ({busy, mret_ack, core_gnt} !== 3'b010) $display("FAIL contend_mret got busy/ack/gnt=%b want 010", {busy, mret_ack, core_gnt});
        else n_pass++;
        tick();
        mret_req = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (core_gnt !== 1'b1 || k !== 6) $display("FAIL contend_core got gnt=%b cycles=%0d want 1 6", core_gnt, k);
        else n_pass++;
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_rv = 1'b0;
        trap_pc = 32'h0000_5678; trap_cause = 32'h0000_000B; trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (csr_we !== 1'b1 || csr_addr !== 32'h342) $display("FAIL mid_state got we=%b addr=%h want 1 342", csr_we, csr_addr);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, csr_we, redirect_valid} !== 3'b000) $display("FAIL mid_reset got busy/we/rv=%b want 000", {busy, csr_we, redirect_valid});
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (redirect_valid === 1'b1 || busy === 1'b1) saw_rv = 1'b1;
        end
        n_checks++;
        if (saw_rv !== 1'b0) $display("FAIL mid_no_redirect got activity=%b want 0", saw_rv);
        else n_pass++;
        n_checks++;
        if (mem[5'h01] !== 32'h5678 || mem[5'h02] !== 32'h3)
            $display("FAIL mid_csrs got mepc=%h mcause=%h want 00005678 00000003", mem[5'h01], mem[5'h02]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_core_access();
        test_direct_trap();
        test_vectored();
        test_mret();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
- Sequencer and arbiter in front of the machine-mode CSR register file (32 x 32-bit, registered read data, one-cycle write).
- On a trap, it saves mepc, mcause and mstatus, reads mtvec and issues a PC redirect.
- On mret, it restores mstatus and redirects to mepc.
- When idle, it passes the core's CSR-instruction port through to the CSR file, so the file has exactly one master at a time.

Parameters:
- ADDR_W, 32, width of CSR address bus to the CSR file
- VECTORED_EN, 1, 1 = honour mtvec MODE=1 (vectored interrupts); 0 = always direct
- MIE_BIT, 3, mstatus MIE bit index
- MPIE_BIT, 7, mstatus MPIE bit index

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- trap_req_i  in  1  trap request; level, held until trap_ack_o
- trap_pc_i  in  32  faulting PC, sampled on accept
- trap_cause_i  in  32  cause (bit31 = interrupt), sampled on accept
- trap_ack_o  out  1  one-cycle pulse: trap accepted
- mret_req_i  in  1  mret request; level, held until mret_ack_o
- mret_ack_o  out  1  one-cycle pulse: mret accepted
- core_req_i  in  1  core CSR access request
- core_we_i  in  1  core write (1) / read (0)
- core_addr_i  in  ADDR_W  core CSR address
- core_wdata_i  in  32  core write data
- core_gnt_o  out  1  core access granted this cycle
- core_rdata_o  out  32  CSR read data to core (valid the cycle after a granted read)
- csr_addr_o  out  ADDR_W  to CSR file address_i
- csr_we_o  out  1  to CSR file en_write_i
- csr_re_o  out  1  to CSR file en_read_i
- csr_wdata_o  out  32  to CSR file data_i
- csr_rdata_i  in  32  from CSR file data_out_o
- redirect_valid_o  out  1  one-cycle pulse: fetch must jump
- redirect_pc_o  out  32  jump target, valid with redirect_valid_o
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_ni low, async):
  - state = IDLE; all outputs 0.
  - Internal latches (pc, cause, mstatus copy, target) = 0.
- Priority in IDLE: trap_req_i > mret_req_i > core_req_i.
- core_gnt_o is combinational: core_req_i & IDLE & !trap_req_i & !mret_req_i.
- When granted: csr_addr_o = core_addr_i, csr_we_o = core_we_i, csr_re_o = !core_we_i, csr_wdata_o = core_wdata_i, all combinationally.
- core_rdata_o = csr_rdata_i at all times.
- CSR addresses used by the sequences: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- Trap sequence (accept edge = E):
  - At E: latch trap_pc_i and trap_cause_i; trap_ack_o is high in the cycle before E (combinational with accept).
  - States, one cycle each, in order:
    - T_RD_ST: re, 0x300
    - T_CAP_ST: capture csr_rdata_i
    - T_WR_EPC: we, 0x341, pc & ~3
    - T_WR_CAUSE: we, 0x342, cause
    - T_WR_ST: we, 0x300, status with MPIE := MIE and MIE := 0
    - T_RD_VEC: re, 0x305
    - T_CAP_VEC: compute target
    - DONE: redirect_valid_o = 1
    - then back to IDLE.
  - redirect_valid_o is high exactly in the 8th cycle after E.
- Target computation:
  - base = {mtvec[31:2], 2'b00}.
  - If VECTORED_EN, mtvec[1:0] == 1 and cause[31] = 1: target = base + (cause[30:0] << 2), truncated to 32 bits (wraps).
  - Otherwise target = base. mtvec MODE 2 and 3 are treated as direct.
- MRET sequence:
  - States, one cycle each: M_RD_ST, M_CAP_ST, M_RD_EPC, M_CAP_EPC (capture target), M_WR_ST (status with MIE := MPIE and MPIE := 1), DONE.
  - redirect_valid_o is high in the 6th cycle after accept. redirect_pc_o = mepc & ~3.
- Outside the listed states, csr_we_o and csr_re_o are 0 and the core is not granted.
- Requests arriving while busy are not accepted; no ack is given. They are evaluated again in the first IDLE cycle after DONE.
- Trap and mret both high in IDLE: trap wins; mret waits.
- redirect_pc_o holds its last value after DONE and changes only at the next capture.
- Async reset mid-sequence: returns to IDLE immediately. CSR writes already performed are not rolled back. No redirect is issued.
- The CSR file's en_except_i is tied low by the integrator; this block never drives it.

Test Plan:
- Reset then core read: core_req_i = 1, core_we_i = 0, core_addr_i = 0x305 after mtvec was written 0x8000_0100 → core_gnt_o = 1; core_rdata_o = 0x8000_0100 the next cycle.
- Direct trap: mtvec = 0x8000_0100, mstatus = 0x0000_0008; trap_pc_i = 0x0000_1236, cause = 0x0000_0002 → writes seen in order: mepc = 0x1234, mcause = 2, mstatus = 0x80. redirect_pc_o = 0x8000_0100 with redirect_valid_o high 8 cycles after accept.
- Vectored interrupt: mtvec = 0x8000_0101, cause = 0x8000_0007 → redirect_pc_o = 0x8000_011C. With VECTORED_EN = 0 → 0x8000_0100.
- MRET: mepc = 0x0000_1234, mstatus = 0x80 → mstatus written 0x88; redirect_pc_o = 0x1234 six cycles after accept.
- Contention: trap, mret and core all requested in the same IDLE cycle → only trap_ack_o fires. mret is acked in the first IDLE cycle after the trap's DONE. core_gnt_o stays 0 throughout.
- Reset in T_WR_CAUSE: rst_ni low → busy_o = 0 immediately; no redirect pulse; mepc holds the new value; mcause is unchanged.
